// File: rtl/switch_ctrl.sv
// switch_ctrl: synchronised, debounced 32-bit image of the four user DIP-switch groups with a maskable change interrupt.
// Define SWITCH_CHG_MASK_EN to add the sticky per-bit change register (CHG) at addr 3.
module switch_ctrl #(
  parameter int unsigned DEB_CYCLES = 20000,
  parameter int unsigned CNT_W      = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  user0_dipsw,
  input  logic [7:0]  user1_dipsw,
  input  logic [7:0]  user2_dipsw,
  input  logic [7:0]  user3_dipsw,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  typedef enum logic {IDLE, COUNT} grpState_e;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEB_CYCLES - 1);

  logic [31:0] sync1_q, sync2_q;
  logic [31:0] stableImg;
  logic [3:0]  commit;
  logic        ie_q, ie_d;
  logic        pend_q, pend_d;
  logic        irq_q;
  logic        wrCtrl, wrStat;

`ifdef SWITCH_CHG_MASK_EN
  logic [31:0] chg_q, chg_d, chgSet;
  logic        wrChg;
`else
  logic        unusedDin;
  assign unusedDin = ^din[31:1];
`endif

  assign wrCtrl = we && (addr == 2'd1);
  assign wrStat = we && (addr == 2'd2);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {user3_dipsw, user2_dipsw, user1_dipsw, user0_dipsw};
      sync2_q <= sync1_q;
    end
  end

  // Each group debounces on its own; a commit needs the same new value seen for DEB_CYCLES+1 edges.
  for (genvar g = 0; g < 4; g++) begin : gGroup
    grpState_e        state_q;
    logic [7:0]       cand_q;
    logic [7:0]       stable_q;
    logic [7:0]       sample;
    logic [CNT_W-1:0] cnt_q;

    assign sample               = sync2_q[8*g +: 8];
    assign stableImg[8*g +: 8]  = stable_q;
    assign commit[g]            = (state_q == COUNT) && (sample != stable_q) &&
                                  (sample == cand_q) && (cnt_q == CntLast);
`ifdef SWITCH_CHG_MASK_EN
    assign chgSet[8*g +: 8]     = commit[g] ? (stable_q ^ cand_q) : 8'h00;
`endif

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q  <= IDLE;
        cand_q   <= '0;
        stable_q <= '0;
        cnt_q    <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (sample != stable_q) begin
              cand_q  <= sample;
              cnt_q   <= '0;
              state_q <= COUNT;
            end
          end
          COUNT: begin
            if (sample == stable_q) begin
              state_q <= IDLE;
            end else if (sample != cand_q) begin
              cand_q <= sample;
              cnt_q  <= '0;
            end else if (cnt_q == CntLast) begin
              stable_q <= cand_q;
              state_q  <= IDLE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        endcase
      end
    end
  end

  // A commit in the same cycle as a PEND clear wins, so a change is never lost.
  always_comb begin
    ie_d   = ie_q;
    pend_d = pend_q;
    if (wrCtrl) ie_d = din[0];
    if (wrStat && din[0]) pend_d = 1'b0;
    if (|commit) pend_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ie_q   <= 1'b0;
      pend_q <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      ie_q   <= ie_d;
      pend_q <= pend_d;
      irq_q  <= pend_q & ie_q;
    end
  end

  assign irq = irq_q;

`ifdef SWITCH_CHG_MASK_EN
  assign wrChg = we && (addr == 2'd3);

  always_comb begin
    chg_d = chg_q;
    if (wrChg) chg_d = chg_d & ~din;
    chg_d = chg_d | chgSet;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      chg_q <= '0;
    end else begin
      chg_q <= chg_d;
    end
  end
`endif

  always_comb begin
    dout = '0;
    case (addr)
      2'd0: dout = stableImg;
      2'd1: dout = {31'd0, ie_q};
      2'd2: dout = {31'd0, pend_q};
      2'd3: begin
`ifdef SWITCH_CHG_MASK_EN
        dout = chg_q;
`else
        dout = '0;
`endif
      end
    endcase
  end

endmodule

// File: tb/tb_switch_ctrl.sv
// tb_switch_ctrl: directed vector table, hand latency sequence and randomized run against a run-length reference model.
// Expectations for CHG follow SWITCH_CHG_MASK_EN when the bench is built with it.
module tb_switch_ctrl;

  localparam int Deb = 4;
`ifdef SWITCH_CHG_MASK_EN
  localparam bit ChgEn = 1'b1;
`else
  localparam bit ChgEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] sw;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  int checks = 0;
  int fails  = 0;

  switch_ctrl #(.DEB_CYCLES(Deb), .CNT_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .user0_dipsw (sw[7:0]),
    .user1_dipsw (sw[15:8]),
    .user2_dipsw (sw[23:16]),
    .user3_dipsw (sw[31:24]),
    .addr        (addr),
    .we          (we),
    .din         (din),
    .dout        (dout),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic [31:0] sw;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] din;
    int          ticks;
    logic [31:0] expDout;
    logic        expIrq;
  } vec_t;

  vec_t vecs [$];

  // Reference: a group commits once its synchronised value has been seen unchanged, and different
  // from the stable value, on DEB_CYCLES+1 consecutive edges.
  logic [31:0] mSync1, mSync2, mStable, mChg;
  logic        mIe, mPend, mIrq;
  logic [7:0]  mLast [4];
  int          mRun  [4];

  task automatic stepModel();
    logic [31:0] chgSet;
    logic        anyCommit;
    logic [7:0]  seen;
    if (reset) begin
      mSync1 = '0; mSync2 = '0; mStable = '0; mChg = '0;
      mIe = 1'b0; mPend = 1'b0; mIrq = 1'b0;
      for (int g = 0; g < 4; g++) begin
        mLast[g] = 8'h00;
        mRun[g]  = 0;
      end
    end else begin
      chgSet    = '0;
      anyCommit = 1'b0;
      for (int g = 0; g < 4; g++) begin
        seen     = mSync2[8*g +: 8];
        mRun[g]  = (seen == mLast[g]) ? mRun[g] + 1 : 1;
        mLast[g] = seen;
        if (seen != mStable[8*g +: 8] && mRun[g] >= Deb + 1) begin
          chgSet[8*g +: 8]  = seen ^ mStable[8*g +: 8];
          mStable[8*g +: 8] = seen;
          anyCommit         = 1'b1;
        end
      end
      mIrq = mPend & mIe;
      if (anyCommit) mPend = 1'b1;
      else if (we && addr == 2'd2 && din[0]) mPend = 1'b0;
      if (we && addr == 2'd1) mIe = din[0];
      if (we && addr == 2'd3) mChg = mChg & ~din;
      mChg   = mChg | chgSet;
      mSync2 = mSync1;
      mSync1 = sw;
    end
  endtask

  function automatic logic [31:0] modelDout();
    case (addr)
      2'd0:    return mStable;
      2'd1:    return {31'd0, mIe};
      2'd2:    return {31'd0, mPend};
      default: return ChgEn ? mChg : 32'h0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    stepModel();
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] expDout, input logic expIrq);
    checks++;
    if (dout !== expDout) begin
      fails++;
      $display("[TB] FAIL %s: dout=%h expected %h", name, dout, expDout);
    end
    checks++;
    if (irq !== expIrq) begin
      fails++;
      $display("[TB] FAIL %s: irq=%b expected %b", name, irq, expIrq);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    reset = v.rst;
    sw    = v.sw;
    addr  = v.addr;
    we    = v.we;
    din   = v.din;
    repeat (v.ticks) tick();
  endtask

  task automatic addVec(input logic r, input logic [31:0] s, input logic [1:0] a, input logic w,
                        input logic [31:0] d, input int t, input logic [31:0] ed, input logic ei);
    vec_t v;
    v.rst = r; v.sw = s; v.addr = a; v.we = w; v.din = d;
    v.ticks = t; v.expDout = ed; v.expIrq = ei;
    vecs.push_back(v);
  endtask

  initial begin
    reset = 1'b1; sw = '0; addr = 2'd0; we = 1'b0; din = '0;
    $display("[TB] switch_ctrl bench, DEB_CYCLES=%0d, CHG enabled=%0d", Deb, ChgEn);

    addVec(1, 32'h00000000, 0, 0, 32'h0,        2,  32'h0, 0);
    addVec(0, 32'h00000000, 0, 0, 32'h0,        20, 32'h0, 0);
    addVec(0, 32'h00000000, 2, 0, 32'h0,        1,  32'h0, 0);
    addVec(0, 32'h00000000, 1, 0, 32'h0,        1,  32'h0, 0);
    addVec(0, 32'h0000A500, 0, 0, 32'h0,        6,  32'h0, 0);
    addVec(0, 32'h0000A500, 0, 0, 32'h0,        1,  32'h0000A500, 0);
    addVec(0, 32'h0000A500, 2, 0, 32'h0,        1,  32'h1, 0);
    addVec(0, 32'h0000A500, 2, 1, 32'h0,        1,  32'h1, 0);
    addVec(0, 32'h0000A500, 2, 1, 32'h1,        1,  32'h0, 0);
    addVec(0, 32'h0000A500, 0, 1, 32'hFFFFFFFF, 1,  32'h0000A500, 0);
    addVec(0, 32'h0000A500, 3, 0, 32'h0,        1,  ChgEn ? 32'h0000A500 : 32'h0, 0);
    addVec(0, 32'h0000A500, 1, 1, 32'h1,        1,  32'h1, 0);
    addVec(0, 32'h0000A501, 0, 0, 32'h0,        2,  32'h0000A500, 0);
    addVec(0, 32'h0000A500, 2, 0, 32'h0,        2,  32'h0, 0);
    addVec(0, 32'h0000A501, 0, 0, 32'h0,        2,  32'h0000A500, 0);
    addVec(0, 32'h0000A500, 2, 0, 32'h0,        2,  32'h0, 0);
    addVec(0, 32'h0000A501, 0, 0, 32'h0,        2,  32'h0000A500, 0);
    addVec(0, 32'h0000A53C, 0, 0, 32'h0,        6,  32'h0000A500, 0);
    addVec(0, 32'h0000A53C, 0, 0, 32'h0,        1,  32'h0000A53C, 0);
    addVec(0, 32'h0000A53C, 2, 0, 32'h0,        1,  32'h1, 1);
    addVec(0, 32'h0000A53C, 2, 1, 32'h1,        1,  32'h0, 1);
    addVec(0, 32'h0000A53C, 2, 0, 32'h0,        1,  32'h0, 0);
    addVec(0, 32'h0000A555, 2, 0, 32'h0,        6,  32'h0, 0);
    addVec(0, 32'h0000A555, 2, 1, 32'h1,        1,  32'h1, 0);
    addVec(0, 32'h0000A555, 0, 0, 32'h0,        1,  32'h0000A555, 1);
    addVec(0, 32'h0000A555, 1, 1, 32'h0,        1,  32'h0, 1);
    addVec(0, 32'h0000A555, 2, 0, 32'h0,        1,  32'h1, 0);
    addVec(0, 32'h0000A555, 2, 1, 32'h1,        1,  32'h0, 0);
    addVec(0, 32'h0000A555, 1, 1, 32'h1,        1,  32'h1, 0);
    addVec(0, 32'h0000A555, 3, 1, 32'hFFFFFFFF, 1,  32'h0, 0);
    addVec(0, 32'h81FFA555, 0, 0, 32'h0,        6,  32'h0000A555, 0);
    addVec(0, 32'h81FFA555, 0, 0, 32'h0,        1,  32'h81FFA555, 0);
    addVec(0, 32'h81FFA555, 2, 0, 32'h0,        1,  32'h1, 1);
    addVec(0, 32'h81FFA555, 2, 1, 32'h1,        1,  32'h0, 1);
    addVec(0, 32'h81FFA555, 2, 0, 32'h0,        2,  32'h0, 0);
    addVec(0, 32'h81FFA555, 3, 0, 32'h0,        1,  ChgEn ? 32'h81FF0000 : 32'h0, 0);
    addVec(0, 32'h81FFA555, 3, 1, 32'h00FF0000, 1,  ChgEn ? 32'h81000000 : 32'h0, 0);
    addVec(0, 32'h81FFA555, 3, 0, 32'h0,        1,  ChgEn ? 32'h81000000 : 32'h0, 0);
    addVec(0, 32'h81FFA5AA, 0, 0, 32'h0,        5,  32'h81FFA555, 0);
    addVec(1, 32'h81FFA5AA, 0, 0, 32'h0,        1,  32'h0, 0);
    addVec(0, 32'h81FFA5AA, 2, 0, 32'h0,        1,  32'h0, 0);
    addVec(0, 32'h81FFA5AA, 0, 0, 32'h0,        5,  32'h0, 0);
    addVec(0, 32'h81FFA5AA, 0, 0, 32'h0,        1,  32'h81FFA5AA, 0);
    addVec(0, 32'h81FFA5AA, 2, 0, 32'h0,        1,  32'h1, 0);
    addVec(0, 32'h81FFA5AA, 1, 0, 32'h0,        1,  32'h0, 0);
    addVec(0, 32'h81FFA5AA, 3, 0, 32'h0,        1,  ChgEn ? 32'h81FFA5AA : 32'h0, 0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i), vecs[i].expDout, vecs[i].expIrq);
    end

    // Edge-exact latency after reset: nothing visible until E0+DEB_CYCLES+2.
    reset = 1'b1; sw = '0; addr = 2'd0; we = 1'b0; din = '0;
    tick(); tick();
    reset = 1'b0;
    sw = 32'h003C0000;
    for (int t = 1; t <= 8; t++) begin
      addr = 2'd0;
      tick();
      checkOutput($sformatf("lat_data_e%0d", t - 1), (t >= 7) ? 32'h003C0000 : 32'h0, 1'b0);
      addr = 2'd2;
      #1;
      checkOutput($sformatf("lat_stat_e%0d", t - 1), (t >= 7) ? 32'h1 : 32'h0, 1'b0);
    end

    for (int c = 0; c < 3000; c++) begin
      for (int g = 0; g < 4; g++) begin
        if ($urandom_range(0, 11) == 0)
          sw[8*g +: 8] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      end
      addr  = 2'($urandom_range(0, 3));
      we    = ($urandom_range(0, 5) == 0);
      din   = $urandom;
      reset = ($urandom_range(0, 599) == 0);
      tick();
      checkOutput($sformatf("rand%0d", c), modelDout(), mIrq);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
